bus_arbiter_mp: RTL and testbench

//  Generalised N-port arbiter for the single shared 128-bit memory bus; successor to the fixed I$/D$ arbiter.

---
 rtl/bus_arbiter_mp_if.sv | 35 +++
 rtl/bus_arbiter_mp.sv | 170 +++++++++++++++++
 tb/tb_bus_arbiter_mp.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_mp_if.sv
// Requestor and shared-memory-bus signals of bus_arbiter_mp, named from the arbiter's side.
// master = arbiter; slave = the requestors plus the memory that drive it.
interface bus_arbiter_mp_if #(
  parameter int NUM_PORTS = 2,
  parameter int AW        = 16,
  parameter int DW        = 128
);
  logic [NUM_PORTS-1:0]    req_valid_i;
  logic [NUM_PORTS-1:0]    req_urgent_i;
  logic [NUM_PORTS-1:0]    req_we_i;
  logic [NUM_PORTS*AW-1:0] req_addr_i;
  logic [NUM_PORTS*DW-1:0] req_data_i;
  logic [NUM_PORTS-1:0]    resp_valid_o;
  logic [DW-1:0]           resp_data_o;
  logic [NUM_PORTS-1:0]    grant_o;
  logic [AW-1:0]           bus_addr_o;
  logic [DW-1:0]           bus_data_o;
  logic                    bus_we_o;
  logic                    bus_valid_o;
  logic [DW-1:0]           bus_data_i;
  logic                    bus_valid_i;
  logic                    timeout_o;

  modport master (
    input  req_valid_i, req_urgent_i, req_we_i, req_addr_i, req_data_i, bus_data_i, bus_valid_i,
    output resp_valid_o, resp_data_o, grant_o, bus_addr_o, bus_data_o, bus_we_o, bus_valid_o,
           timeout_o
  );

  modport slave (
    output req_valid_i, req_urgent_i, req_we_i, req_addr_i, req_data_i, bus_data_i, bus_valid_i,
    input  resp_valid_o, resp_data_o, grant_o, bus_addr_o, bus_data_o, bus_we_o, bus_valid_o,
           timeout_o
  );
endinterface

// File: rtl/bus_arbiter_mp.sv
// N-port arbiter for the shared memory bus: round-robin or fixed priority, urgent override,
// registered response data. Define BUS_ARB_TIMEOUT_EN to add the BUSY watchdog (timeout_o).
module bus_arbiter_mp #(
  parameter int NUM_PORTS            = 2,
  parameter int BUS_ADDRESS_WIDTH    = 20,
  parameter int BUS_DATA_WIDTH_SHIFT = 4,
  parameter int ARB_MODE             = 0,
  parameter int TIMEOUT_CYCLES       = 255
) (
  input logic              clk_i,
  input logic              rst_i,
  bus_arbiter_mp_if.master bus
);
  localparam int BUS_DATA_WIDTH = 8 << BUS_DATA_WIDTH_SHIFT;
  localparam int AW             = BUS_ADDRESS_WIDTH - BUS_DATA_WIDTH_SHIFT;
  localparam int IW             = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [NUM_PORTS-1:0]      grant_q, grant_d;
  logic [NUM_PORTS-1:0]      resp_valid_q, resp_valid_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic [BUS_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BUS_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      we_q, we_d;
  logic                      valid_q, valid_d;
  logic [IW-1:0]             last_q, last_d;
  logic [IW-1:0]             owner_q, owner_d;

  logic [NUM_PORTS-1:0]      urgent, cand;
  logic [IW-1:0]             win, idx;
  logic                      found;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
`endif

  // Urgent requestors, when present, are the only candidates.
  always_comb begin
    urgent = bus.req_valid_i & bus.req_urgent_i;
    cand   = (|urgent) ? urgent : bus.req_valid_i;
    win    = '0;
    idx    = '0;
    found  = 1'b0;
    if (ARB_MODE == 1) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (cand[i]) win = IW'(i);
      end
    end else begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        idx = IW'((int'(last_q) + k) % NUM_PORTS);
        if (!found && cand[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    resp_valid_d = '0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    we_d         = we_q;
    valid_d      = valid_q;
    last_d       = last_q;
    owner_d      = owner_q;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|bus.req_valid_i) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          addr_d       = bus.req_addr_i[win*AW +: AW];
          wdata_d      = bus.req_data_i[win*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
          we_d         = bus.req_we_i[win];
          valid_d      = 1'b1;
          owner_d      = win;
          if (ARB_MODE == 0) last_d = win;
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
          state_d      = S_BUSY;
        end
      end
      S_BUSY: begin
        // Memory completion beats a watchdog expiry in the same cycle.
        if (bus.bus_valid_i) begin
          valid_d               = 1'b0;
          grant_d               = '0;
          resp_valid_d[owner_q] = 1'b1;
          if (!we_q) rdata_d    = bus.bus_data_i;
          state_d               = S_DONE;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          valid_d               = 1'b0;
          grant_d               = '0;
          resp_valid_d[owner_q] = 1'b1;
          timeout_d             = 1'b1;
          state_d               = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      resp_valid_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      we_q         <= 1'b0;
      valid_q      <= 1'b0;
      last_q       <= IW'(NUM_PORTS - 1);
      owner_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      resp_valid_q <= resp_valid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      we_q         <= we_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  assign bus.timeout_o = 1'b0;
`endif

  assign bus.grant_o      = grant_q;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_data_o  = rdata_q;
  assign bus.bus_addr_o   = addr_q;
  assign bus.bus_data_o   = wdata_q;
  assign bus.bus_we_o     = we_q;
  assign bus.bus_valid_o  = valid_q;
endmodule

// File: tb/tb_bus_arbiter_mp.sv
// Directed bench for bus_arbiter_mp: a round-robin and a fixed-priority instance, memory responder
// and requestors driven from one initial block, expected transactions kept in a scoreboard queue.
module tb_bus_arbiter_mp;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 128;
  localparam int TO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_mp_if #(.NUM_PORTS(N), .AW(AW), .DW(DW)) if_rr ();
  bus_arbiter_mp_if #(.NUM_PORTS(N), .AW(AW), .DW(DW)) if_fx ();

  bus_arbiter_mp #(.NUM_PORTS(N), .BUS_ADDRESS_WIDTH(20), .BUS_DATA_WIDTH_SHIFT(4),
                   .ARB_MODE(0), .TIMEOUT_CYCLES(TO))
    u_rr (.clk_i(clk), .rst_i(rst_n), .bus(if_rr.master));
  bus_arbiter_mp #(.NUM_PORTS(N), .BUS_ADDRESS_WIDTH(20), .BUS_DATA_WIDTH_SHIFT(4),
                   .ARB_MODE(1), .TIMEOUT_CYCLES(TO))
    u_fx (.clk_i(clk), .rst_i(rst_n), .bus(if_fx.master));

  // sel routes the shared stimulus to one instance and its outputs back to the checks.
  logic              sel;
  logic [N-1:0]      req_v, req_u, req_we;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [DW-1:0]     mem_data;
  logic              mem_valid;

  assign if_rr.req_valid_i  = sel ? '0 : req_v;
  assign if_rr.req_urgent_i = sel ? '0 : req_u;
  assign if_rr.req_we_i     = req_we;
  assign if_rr.req_addr_i   = req_addr;
  assign if_rr.req_data_i   = req_data;
  assign if_rr.bus_data_i   = mem_data;
  assign if_rr.bus_valid_i  = sel ? 1'b0 : mem_valid;
  assign if_fx.req_valid_i  = sel ? req_v : '0;
  assign if_fx.req_urgent_i = sel ? req_u : '0;
  assign if_fx.req_we_i     = req_we;
  assign if_fx.req_addr_i   = req_addr;
  assign if_fx.req_data_i   = req_data;
  assign if_fx.bus_data_i   = mem_data;
  assign if_fx.bus_valid_i  = sel ? mem_valid : 1'b0;

  logic [N-1:0]  o_grant, o_resp_valid;
  logic [DW-1:0] o_resp_data, o_wdata;
  logic [AW-1:0] o_addr;
  logic          o_we, o_bus_valid, o_timeout;

  assign o_grant      = sel ? if_fx.grant_o      : if_rr.grant_o;
  assign o_resp_valid = sel ? if_fx.resp_valid_o : if_rr.resp_valid_o;
  assign o_resp_data  = sel ? if_fx.resp_data_o  : if_rr.resp_data_o;
  assign o_wdata      = sel ? if_fx.bus_data_o   : if_rr.bus_data_o;
  assign o_addr       = sel ? if_fx.bus_addr_o   : if_rr.bus_addr_o;
  assign o_we         = sel ? if_fx.bus_we_o     : if_rr.bus_we_o;
  assign o_bus_valid  = sel ? if_fx.bus_valid_o  : if_rr.bus_valid_o;
  assign o_timeout    = sel ? if_fx.timeout_o    : if_rr.timeout_o;

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mdata;
    logic [DW-1:0] rexp;
  } txn_t;

  txn_t          sb[$];
  logic [DW-1:0] model_r;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected response data follows the last read line; writes leave it alone.
  task automatic push_txn(input int port, input logic [DW-1:0] mdata);
    txn_t t;
    t.port  = port;
    t.we    = req_we[port];
    t.addr  = req_addr[port*AW +: AW];
    t.wdata = req_data[port*DW +: DW];
    t.mdata = mdata;
    if (!t.we) model_r = mdata;
    t.rexp  = model_r;
    sb.push_back(t);
  endtask

  task automatic setreq(input int port, input logic urg, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] mdata, input bit expect_it);
    req_v[port]               = 1'b1;
    req_u[port]               = urg;
    req_we[port]              = we;
    req_addr[port*AW +: AW]   = addr;
    req_data[port*DW +: DW]   = wdata;
    if (expect_it) push_txn(port, mdata);
  endtask

  task automatic wait_busy(output int waited);
    waited = 0;
    while (o_bus_valid !== 1'b1 && waited < 64) begin
      cyc();
      waited++;
    end
    chk("wait_bus_valid", waited < 64, 1);
  endtask

  // Memory answers lat cycles after bus_valid_o; requestors in drop release their request on the pulse.
  task automatic serve(input int lat, input logic [N-1:0] drop, output int waited);
    txn_t t;
    wait_busy(waited);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", sb.size(), 1);
      return;
    end
    t = sb.pop_front();
    chk("grant", o_grant, 1 << t.port);
    chk("bus_addr", o_addr, t.addr);
    chk("bus_we", o_we, t.we);
    chk("bus_data", o_wdata, t.wdata);
    repeat (lat) cyc();
    chk("held_valid", {o_bus_valid, o_grant}, {1'b1, 4'(1 << t.port)});
    chk("held_addr", o_addr, t.addr);
    mem_valid = 1'b1;
    mem_data  = t.mdata;
    cyc();
    mem_valid = 1'b0;
    mem_data  = ~t.mdata;
    chk("resp_valid", o_resp_valid, 1 << t.port);
    chk("resp_data", o_resp_data, t.rexp);
    chk("bus_released", {o_bus_valid, o_grant}, 0);
    chk("no_timeout", o_timeout, 0);
    req_v &= ~drop;
    req_u &= ~drop;
    cyc();
    chk("resp_pulse_end", o_resp_valid, 0);
  endtask

  initial begin
    int w;
    int n;
    sel       = 1'b0;
    req_v     = '0;
    req_u     = '0;
    req_we    = '0;
    req_addr  = '0;
    req_data  = '0;
    mem_data  = '0;
    mem_valid = 1'b0;
    model_r   = '0;

    repeat (3) cyc();
    chk("rst_grant", o_grant, 0);
    chk("rst_bus_valid", o_bus_valid, 0);
    chk("rst_resp_valid", o_resp_valid, 0);
    chk("rst_resp_data", o_resp_data, 0);
    chk("rst_timeout", o_timeout, 0);
    rst_n = 1'b1;
    cyc();

    // Reset in the middle of a transaction abandons it.
    setreq(2, 1'b0, 1'b0, 16'h0777, '0, '0, 1'b0);
    wait_busy(w);
    chk("pre_rst_grant", o_grant, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("async_rst_bus", {o_bus_valid, o_grant, o_resp_valid, o_timeout}, 0);
    chk("async_rst_addr", o_addr, 0);
    req_v = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Round-robin between two continuous requestors; gap of 2 idle cycles between grants.
    setreq(0, 1'b0, 1'b0, 16'h0A00, '0, {4{32'h1111_0000}}, 1'b1);
    setreq(1, 1'b0, 1'b0, 16'h0B00, '0, {4{32'h2222_0000}}, 1'b1);
    push_txn(0, {4{32'h3333_0000}});
    serve(3, 4'b0000, w);
    chk("rr_first_latency", w, 1);
    serve(3, 4'b0000, w);
    chk("rr_gap1", w, 1);
    serve(3, 4'b0011, w);
    chk("rr_gap2", w, 1);

    // Urgent requestor outranks earlier ones, then round-robin resumes.
    setreq(3, 1'b1, 1'b0, 16'h0D03, '0, {4{32'h4444_3333}}, 1'b1);
    setreq(0, 1'b0, 1'b0, 16'h0D00, '0, {4{32'h4444_0000}}, 1'b1);
    setreq(2, 1'b0, 1'b0, 16'h0D02, '0, {4{32'h4444_2222}}, 1'b1);
    serve(2, 4'b1000, w);
    serve(2, 4'b0001, w);
    serve(2, 4'b0100, w);

    // Read of line 0x123, then a write that must not disturb the read data.
    setreq(1, 1'b0, 1'b0, 16'h0123, '0, {16{8'hA5}}, 1'b1);
    serve(1, 4'b0010, w);
    setreq(0, 1'b0, 1'b1, 16'h0456, {4{32'hDEAD_BEEF}}, {16{8'h3C}}, 1'b1);
    serve(1, 4'b0001, w);

    // Stray memory completion while idle.
    mem_valid = 1'b1;
    mem_data  = {8{16'h5AA5}};
    cyc();
    mem_valid = 1'b0;
    chk("idle_bv_resp", o_resp_valid, 0);
    chk("idle_bv_data", o_resp_data, model_r);
    chk("idle_bv_bus", o_bus_valid, 0);

`ifdef BUS_ARB_TIMEOUT_EN
    setreq(2, 1'b0, 1'b0, 16'h0E02, '0, '0, 1'b0);
    wait_busy(w);
    n = 0;
    while (o_timeout !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk("timeout_delay", n, TO);
    chk("timeout_resp", o_resp_valid, 4'b0100);
    chk("timeout_data", o_resp_data, model_r);
    chk("timeout_bus", {o_bus_valid, o_grant}, 0);
    req_v = '0;
    cyc();
    chk("timeout_pulse_end", {o_timeout, o_resp_valid}, 0);
    setreq(1, 1'b0, 1'b0, 16'h0E01, '0, {4{32'hCAFE_F00D}}, 1'b1);
    serve(TO - 1, 4'b0010, w);
`else
    setreq(2, 1'b0, 1'b0, 16'h0E02, '0, {4{32'h600D_600D}}, 1'b1);
    serve(30, 4'b0100, w);
`endif

    // Fixed priority: port 1 keeps winning over port 2.
    sel     = 1'b1;
    model_r = '0;
    cyc();
    setreq(1, 1'b0, 1'b0, 16'h0111, '0, {4{32'h7777_0001}}, 1'b1);
    setreq(2, 1'b0, 1'b0, 16'h0222, '0, '0, 1'b0);
    push_txn(1, {4{32'h7777_0002}});
    push_txn(1, {4{32'h7777_0003}});
    serve(2, 4'b0000, w);
    serve(2, 4'b0000, w);
    serve(2, 4'b0110, w);
    cyc();
    chk("fx_idle", {o_bus_valid, o_grant}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
